ro_count_sampler: RTL and testbench
===================================

// Module: ro_count_sampler
// PURPOSE
//  Downstream consumer of Counting_circuit.value_out (free-running 8-bit ring-edge count).
//  Measures ring-oscillator frequency: samples the count every WINDOW clk cycles and takes
//  the modulo-256 delta. Accumulates 2**LOG2_NWIN back-to-back windows.
//  Presents sum and average with a valid/ready handshake to the readout/PUF-compare logic.
// PARAMETERS
//  WINDOW     64  clk cycles per measurement window (>=2); must give <=255 ring edges/window
//  LOG2_NWIN  2   log2 of number of windows accumulated per measurement (0..8)
// PORTS
//  clk        in   1             system clock, all logic rising-edge
//  rst_n      in   1             synchronous, active-low reset
//  value_in   in   8             ring edge count from Counting_circuit, clk-domain, wraps 255->0
//  start      in   1             1-cycle request to begin a measurement (honoured in IDLE only)
//  busy       out  1             high from the cycle after accepted start until handshake completes
//  sum_out    out  8+LOG2_NWIN   sum of window deltas
//  avg_out    out  8             sum_out >> LOG2_NWIN (truncating)
//  out_valid  out  1             result valid; held until out_ready
//  out_ready  in   1             consumer accepts result when out_valid && out_ready
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; busy, out_valid, sum_out, avg_out, internal
//    base/acc/timer/window counters all 0. Reset wins over every other input, any state.
//  - FSM states: IDLE -> COUNT -> DONE -> IDLE.
//  - IDLE: start=1 -> base<=value_in, tmr<=0, win<=0, acc<=0, go COUNT. Otherwise hold.
//  - COUNT: tmr increments every cycle. At tmr==WINDOW-1:
//    delta = (value_in - base) mod 256 (8-bit subtract, borrow discarded);
//    acc += delta; base <= value_in; tmr <= 0; win++.
//    Windows are contiguous; no dead cycle between windows.
//    If win == 2**LOG2_NWIN-1 at that edge: sum_out<=acc+delta, avg_out<=(acc+delta)>>LOG2_NWIN,
//    out_valid<=1, go DONE.
//  - DONE: sum_out/avg_out/out_valid stable while out_ready=0.
//    On out_valid&&out_ready: out_valid<=0, busy<=0, go IDLE.
//    sum_out/avg_out keep last value until the next result.
//  - start ignored in COUNT and DONE (no queuing).
//    start in the same cycle as a completing handshake is ignored; earliest restart is next cycle.
//  - Latency: start at cycle 0 -> out_valid at cycle 1 + WINDOW*2**LOG2_NWIN.
//  - Wrap: value_in crossing 255->0 within a window yields the correct delta by modulo arithmetic.
//    More than 255 edges per window aliases (delta mod 256). This is a documented limitation,
//    not detected.
//  - acc width 8+LOG2_NWIN; it cannot overflow.
//  - busy = (state != IDLE), registered.
// CONFIGURATION
//  - RO_MINMAX_EN defined: extra outputs min_delta[7:0], max_delta[7:0].
//    Both reset to 0. At start, min<=8'hFF and max<=0.
//    Each window close updates min/max with delta. Values are latched alongside sum_out
//    and held with out_valid.
//  - Not defined: ports and logic absent; all other behaviour identical.
// TESTING
//  - Bench models value_in as a counter incrementing every 2nd clk (Ring_in half of clk freq).
//  - Basic: WINDOW=64, LOG2_NWIN=2, value_in from 0, start pulse, out_ready=1
//    -> out_valid at cycle 257; sum_out=128, avg_out=32; busy low next cycle.
//  - Wrap: same but value_in starts at 250 -> sum_out=128, avg_out=32 (no wrap error).
//  - Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid, sum_out, avg_out
//    unchanged; accepted on first ready cycle, then IDLE.
//  - start pulses during COUNT and DONE -> ignored; exactly one result; latency still 257.
//  - Reset mid-COUNT (rst_n=0 at cycle 100, 1 cycle) -> all outputs 0, IDLE.
//    New start then gives sum_out=128.
//  - RO_MINMAX_EN: value_in step alternating 1/2-cycle rates per window
//    -> min_delta=32, max_delta=64 match per-window deltas.

Source files
------------

// File: rtl/ro_count_sampler.sv
// Ring-oscillator frequency meter: sums 2**LOG2_NWIN contiguous WINDOW-cycle count deltas (RO_MINMAX_EN adds min/max).
// Latency: out_valid appears WINDOW*2**LOG2_NWIN+1 cycles after the start cycle; result held until out_ready.
// Backpressure: start is ignored while busy; no request queuing.
module ro_count_sampler #(
   parameter int WINDOW    = 64,
   parameter int LOG2_NWIN = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             value_in,
   input  logic                   start,
   output logic                   busy,
   output logic [8+LOG2_NWIN-1:0] sum_out,
   output logic [7:0]             avg_out,
   output logic                   out_valid,
   input  logic                   out_ready
`ifdef RO_MINMAX_EN
   ,
   output logic [7:0]             min_delta,
   output logic [7:0]             max_delta
`endif
);

   localparam int SW   = 8 + LOG2_NWIN;
   localparam int TW   = $clog2(WINDOW);
   localparam int WW   = (LOG2_NWIN > 0) ? LOG2_NWIN : 1;
   localparam int NWIN = 1 << LOG2_NWIN;

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t         state;
   logic [7:0]     base;
   logic [SW-1:0]  acc;
   logic [TW-1:0]  tmr;
   logic [WW-1:0]  win;

   logic [7:0]     delta;
   logic [SW-1:0]  sum_next;
   logic           win_end;
   logic           last_win;
`ifdef RO_MINMAX_EN
   logic [7:0]     min_run;
   logic [7:0]     max_run;
   logic [7:0]     min_next;
   logic [7:0]     max_next;
`endif

   // Modulo-256 subtract gives the right edge count across a 255->0 wrap.
   always_comb begin
      delta    = value_in - base;
      sum_next = acc + SW'(delta);
      win_end  = (tmr == TW'(WINDOW - 1));
      last_win = (win == WW'(NWIN - 1));
`ifdef RO_MINMAX_EN
      min_next = (delta < min_run) ? delta : min_run;
      max_next = (delta > max_run) ? delta : max_run;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         sum_out   <= '0;
         avg_out   <= '0;
         base      <= '0;
         acc       <= '0;
         tmr       <= '0;
         win       <= '0;
`ifdef RO_MINMAX_EN
         min_run   <= '0;
         max_run   <= '0;
         min_delta <= '0;
         max_delta <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base  <= value_in;
                  tmr   <= '0;
                  win   <= '0;
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= COUNT;
`ifdef RO_MINMAX_EN
                  min_run <= 8'hFF;
                  max_run <= 8'h00;
`endif
               end
            end
            COUNT: begin
               tmr <= tmr + TW'(1);
               // Window close re-bases on the same sample, so windows abut with no dead cycle.
               if (win_end) begin
                  acc  <= sum_next;
                  base <= value_in;
                  tmr  <= '0;
                  win  <= win + WW'(1);
`ifdef RO_MINMAX_EN
                  min_run <= min_next;
                  max_run <= max_next;
`endif
                  if (last_win) begin
                     sum_out   <= sum_next;
                     avg_out   <= 8'(sum_next >> LOG2_NWIN);
                     out_valid <= 1'b1;
                     state     <= DONE;
`ifdef RO_MINMAX_EN
                     min_delta <= min_next;
                     max_delta <= max_next;
`endif
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_count_sampler.sv
// Bench for ro_count_sampler: directed scenarios plus random traffic against a cycle-level model.
module tb_ro_count_sampler;

   localparam int W  = 64;
   localparam int L  = 2;
   localparam int N  = 1 << L;
   localparam int SW = 8 + L;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    value_in;
   logic          start = 1'b0;
   logic          busy;
   logic [SW-1:0] sum_out;
   logic [7:0]    avg_out;
   logic          out_valid;
   logic          out_ready = 1'b1;
`ifdef RO_MINMAX_EN
   logic [7:0]    min_delta;
   logic [7:0]    max_delta;
`endif

   ro_count_sampler #(.WINDOW(W), .LOG2_NWIN(L)) dut (
      .clk(clk), .rst_n(rst_n), .value_in(value_in), .start(start), .busy(busy),
      .sum_out(sum_out), .avg_out(avg_out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef RO_MINMAX_EN
      , .min_delta(min_delta), .max_delta(max_delta)
`endif
   );

   always #5 clk = ~clk;

   // Unwrapped ring-edge count; the DUT only sees its low 8 bits.
   int  edges = 0;
   int  rate = 0;
   bit  ph = 1'b0;
   int  cyc = 0;
   int  total = 0;
   int  bad = 0;
   bit  chk_en = 1'b0;

   assign value_in = edges[7:0];
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: result = true edges elapsed over W*N cycles after the start edge.
   logic          m_busy = 1'b0;
   logic          m_valid = 1'b0;
   logic [SW-1:0] m_sum = '0;
   logic [7:0]    m_avg = '0;
   int            m_left = 0;
   int            m_base = 0;
`ifdef RO_MINMAX_EN
   int            m_wbase = 0;
   int            m_min = 0;
   int            m_max = 0;
   logic [7:0]    m_min_o = '0;
   logic [7:0]    m_max_o = '0;
`endif

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_valid <= 1'b0; m_sum <= '0; m_avg <= '0; m_left <= 0; m_base <= 0;
`ifdef RO_MINMAX_EN
         m_wbase <= 0; m_min <= 0; m_max <= 0; m_min_o <= '0; m_max_o <= '0;
`endif
      end else if (!m_busy) begin
         if (start) begin
            m_busy <= 1'b1; m_base <= edges; m_left <= W * N;
`ifdef RO_MINMAX_EN
            m_wbase <= edges; m_min <= 255; m_max <= 0;
`endif
         end
      end else if (!m_valid) begin
         m_left <= m_left - 1;
`ifdef RO_MINMAX_EN
         if (m_left % W == 1) begin
            m_wbase <= edges;
            m_min   <= min2(m_min, edges - m_wbase);
            m_max   <= max2(m_max, edges - m_wbase);
            if (m_left == 1) begin
               m_min_o <= 8'(min2(m_min, edges - m_wbase));
               m_max_o <= 8'(max2(m_max, edges - m_wbase));
            end
         end
`endif
         if (m_left == 1) begin
            m_valid <= 1'b1;
            m_sum   <= SW'(edges - m_base);
            m_avg   <= 8'((edges - m_base) >> L);
         end
      end else if (out_ready) begin
         m_valid <= 1'b0; m_busy <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      case (rate)
         0: begin ph = !ph; if (ph) edges++; end
         1: edges++;
         default: edges += $urandom_range(0, 3);
      endcase
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("sum_out", 32'(sum_out), 32'(m_sum));
         check("avg_out", 32'(avg_out), 32'(m_avg));
`ifdef RO_MINMAX_EN
         check("min_delta", 32'(min_delta), 32'(m_min_o));
         check("max_delta", 32'(max_delta), 32'(m_max_o));
`endif
      end
   endtask

   // Starts a measurement and returns cycles from start to out_valid (-1 on timeout).
   task automatic measure(input int limit, output int lat);
      int s;
      int n;
      s = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      if (out_valid !== 1'b1) begin
         check("valid_timeout", 32'(n), 32'(-1));
         lat = -1;
      end else begin
         lat = cyc - s;
      end
   endtask

   task automatic run_basic(input string tag, input int e0);
      int lat;
      edges = e0; rate = 0; out_ready = 1'b1;
      tick();
      measure(400, lat);
      check({tag, "_latency"}, 32'(lat), 32'd257);
      check({tag, "_sum"}, 32'(sum_out), 32'd128);
      check({tag, "_avg"}, 32'(avg_out), 32'd32);
      tick();
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_sum", 32'(sum_out), 32'd0);
      rst_n = 1'b1;
      tick();

      run_basic("basic", 0);
      run_basic("wrap", 250);

      // Backpressure: result must hold for 10 unready cycles.
      edges = 17; out_ready = 1'b0;
      measure(400, lat);
      check("bp_latency", 32'(lat), 32'd257);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_sum", 32'(sum_out), 32'd128);
         check("bp_hold_avg", 32'(avg_out), 32'd32);
      end
      out_ready = 1'b1;
      tick();
      check("bp_accept_valid", 32'(out_valid), 32'd0);
      check("bp_accept_busy", 32'(busy), 32'd0);

      // Stray start pulses while busy must not disturb timing or cause a second result.
      fork
         begin
            repeat (50) @(posedge clk);
            #3 start = 1'b1;
            @(posedge clk);
            #3 start = 1'b0;
         end
      join_none
      measure(400, lat);
      check("ignore_latency", 32'(lat), 32'd257);
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      repeat (5) tick();
      check("ignore_no_second", 32'(busy), 32'd0);

      // Reset in the middle of a measurement.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (99) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_sum", 32'(sum_out), 32'd0);
      check("midreset_avg", 32'(avg_out), 32'd0);
      repeat (3) tick();
      run_basic("after_reset", 5);

`ifdef RO_MINMAX_EN
      // Alternate half-rate / full-rate windows: deltas 32,64,32,64.
      start = 1'b1;
      for (int w = 0; w < N; w++) begin
         rate = w % 2;
         repeat (W) begin
            tick();
            start = 1'b0;
         end
      end
      tick();
      check("mm_valid", 32'(out_valid), 32'd1);
      check("mm_min", 32'(min_delta), 32'd32);
      check("mm_max", 32'(max_delta), 32'd64);
      check("mm_sum", 32'(sum_out), 32'd192);
      tick();
`endif

      // Random ring rate, start requests and consumer readiness.
      rate = 2;
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      start = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
